// File: rtl/mn_matrix_stream_if.sv
// Command/data bundle for mn_matrix_stream.
// The loader/solver side drives the master modport; the matrix store is the slave.
`timescale 1ns/1ps
interface mn_matrix_stream_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              clear;
  logic [ADDR_W-1:0] m_dim;
  logic [ADDR_W-1:0] n_dim;
  logic              wr_en;
  logic              rd_en;
  logic              transpose;
  logic [ADDR_W-1:0] m_addr;
  logic [ADDR_W-1:0] n_addr;
  logic              burst_start;
  logic              burst_wr;
  logic [DATA_W-1:0] data_in;
  logic              in_valid;
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output clear, m_dim, n_dim, wr_en, rd_en, transpose, m_addr, n_addr,
           burst_start, burst_wr, data_in, in_valid,
    input  data_out, out_valid, busy, done, err
  );

  modport slave (
    input  clear, m_dim, n_dim, wr_en, rd_en, transpose, m_addr, n_addr,
           burst_start, burst_wr, data_in, in_valid,
    output data_out, out_valid, busy, done, err
  );
endinterface

// File: rtl/mn_matrix_stream.sv
// Dense M_MAX x N_MAX matrix store with random access, row/column-order bursts and sequenced clear.
// Optional MN_MATRIX_RDPIPE_EN adds an output register stage (read latency 2).
`timescale 1ns/1ps
module mn_matrix_stream #(
  parameter int DATA_W = 32,
  parameter int M_MAX  = 128,
  parameter int N_MAX  = 128,
  parameter int ADDR_W = 8
) (
  input logic               clk,
  input logic               reset,
  mn_matrix_stream_if.slave bus
);
  localparam int DEPTH = M_MAX * N_MAX;
  localparam int MA_W  = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] M_LIM = ADDR_W'(M_MAX);
  localparam logic [ADDR_W-1:0] N_LIM = ADDR_W'(N_MAX);

  typedef enum logic [1:0] {IDLE, CLEAR, WBURST, RBURST} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] m_lim_q, m_lim_d, n_lim_q, n_lim_d;
  logic [ADDR_W-1:0] outer_q, outer_d, inner_q, inner_d;
  logic              tr_q, tr_d, fin_q, fin_d;
  logic [MA_W-1:0]   clr_q, clr_d;
  logic              done_q, done_d, err_q, err_d;
  logic              rv1_q, rv1_d, rl1_q, rl1_d;
  logic              rb_done;

  logic              mem_we, mem_re;
  logic [MA_W-1:0]   mem_waddr, mem_raddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] ram_q;

  function automatic logic [MA_W-1:0] mem_index(input logic [ADDR_W-1:0] row,
                                                input logic [ADDR_W-1:0] col);
    return MA_W'(row) * MA_W'(N_MAX) + MA_W'(col);
  endfunction

  // Burst cursor: in IDLE it points at the first element using the live command inputs,
  // so a read burst can issue its first address in the burst_start cycle.
  logic              in_idle, c_tr, i_wrap, c_last;
  logic [ADDR_W-1:0] c_m, c_n, c_outer, c_inner, olim, ilim, nxt_outer, nxt_inner;
  logic [ADDR_W-1:0] c_row, c_col, ra_row, ra_col;
  logic [MA_W-1:0]   cur_idx, ra_idx;
  logic              ra_ok, dims_bad;

  always_comb begin
    in_idle   = (state_q == IDLE);
    c_tr      = in_idle ? bus.transpose : tr_q;
    c_m       = in_idle ? bus.m_dim : m_lim_q;
    c_n       = in_idle ? bus.n_dim : n_lim_q;
    c_outer   = in_idle ? '0 : outer_q;
    c_inner   = in_idle ? '0 : inner_q;
    olim      = c_tr ? c_n : c_m;
    ilim      = c_tr ? c_m : c_n;
    i_wrap    = (c_inner == ilim - ONE);
    c_last    = i_wrap && (c_outer == olim - ONE);
    nxt_inner = i_wrap ? '0 : c_inner + ONE;
    nxt_outer = i_wrap ? c_outer + ONE : c_outer;
    c_row     = c_tr ? c_inner : c_outer;
    c_col     = c_tr ? c_outer : c_inner;
    cur_idx   = mem_index(c_row, c_col);
    ra_row    = bus.transpose ? bus.n_addr : bus.m_addr;
    ra_col    = bus.transpose ? bus.m_addr : bus.n_addr;
    ra_idx    = mem_index(ra_row, ra_col);
    ra_ok     = (ra_row < bus.m_dim) && (ra_col < bus.n_dim) &&
                (ra_row < M_LIM) && (ra_col < N_LIM);
    dims_bad  = (bus.m_dim == '0) || (bus.n_dim == '0) ||
                (bus.m_dim > M_LIM) || (bus.n_dim > N_LIM);
  end

  always_comb begin
    state_d   = state_q;
    m_lim_d   = m_lim_q;
    n_lim_d   = n_lim_q;
    tr_d      = tr_q;
    outer_d   = outer_q;
    inner_d   = inner_q;
    fin_d     = fin_q;
    clr_d     = clr_q;
    done_d    = 1'b0;
    err_d     = err_q;
    rv1_d     = 1'b0;
    rl1_d     = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_waddr = cur_idx;
    mem_raddr = cur_idx;
    mem_wdata = bus.data_in;
    // Clear wins from any state; dropping rv1/rl1 here kills in-flight burst output and done.
    if (bus.clear) begin
      state_d = CLEAR;
      clr_d   = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.burst_start) begin
            m_lim_d = bus.m_dim;
            n_lim_d = bus.n_dim;
            tr_d    = bus.transpose;
            outer_d = '0;
            inner_d = '0;
            fin_d   = 1'b0;
            if (dims_bad) begin
              err_d  = 1'b1;
              done_d = 1'b1;
            end else if (bus.burst_wr) begin
              state_d = WBURST;
            end else begin
              state_d = RBURST;
              mem_re  = 1'b1;
              rv1_d   = 1'b1;
              rl1_d   = c_last;
              fin_d   = c_last;
              outer_d = nxt_outer;
              inner_d = nxt_inner;
            end
          end else if (bus.wr_en) begin
            if (ra_ok) begin
              mem_we    = 1'b1;
              mem_waddr = ra_idx;
            end else begin
              err_d = 1'b1;
            end
          end else if (bus.rd_en) begin
            if (ra_ok) begin
              mem_re    = 1'b1;
              mem_raddr = ra_idx;
              rv1_d     = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        CLEAR: begin
          mem_we    = 1'b1;
          mem_waddr = clr_q;
          mem_wdata = '0;
          clr_d     = clr_q + MA_W'(1);
          if (clr_q == MA_W'(DEPTH - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        WBURST: begin
          if (bus.in_valid) begin
            mem_we  = 1'b1;
            outer_d = nxt_outer;
            inner_d = nxt_inner;
            if (c_last) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        RBURST: begin
          if (!fin_q) begin
            mem_re  = 1'b1;
            rv1_d   = 1'b1;
            rl1_d   = c_last;
            fin_d   = c_last;
            outer_d = nxt_outer;
            inner_d = nxt_inner;
          end
          if (rb_done) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      m_lim_q <= '0;
      n_lim_q <= '0;
      tr_q    <= 1'b0;
      outer_q <= '0;
      inner_q <= '0;
      fin_q   <= 1'b0;
      clr_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rv1_q   <= 1'b0;
      rl1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_lim_q <= m_lim_d;
      n_lim_q <= n_lim_d;
      tr_q    <= tr_d;
      outer_q <= outer_d;
      inner_q <= inner_d;
      fin_q   <= fin_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rv1_q   <= rv1_d;
      rl1_q   <= rl1_d;
    end
  end

  // Storage is deliberately unreset so it maps onto block RAM with a registered read port.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    if (mem_re) ram_q <= mem_q[mem_raddr];
  end

`ifdef MN_MATRIX_RDPIPE_EN
  logic              rv2_q, rl2_q;
  logic [DATA_W-1:0] d2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rv2_q <= 1'b0;
      rl2_q <= 1'b0;
      d2_q  <= '0;
    end else begin
      rv2_q <= rv1_q & ~bus.clear;
      rl2_q <= rl1_q & ~bus.clear;
      if (rv1_q) d2_q <= ram_q;
    end
  end

  assign rb_done       = rl2_q;
  assign bus.out_valid = rv2_q;
  assign bus.data_out  = d2_q;
`else
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] dout;

  assign dout = rv1_q ? ram_q : hold_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hold_q <= '0;
    else       hold_q <= dout;
  end

  assign rb_done       = rl1_q;
  assign bus.out_valid = rv1_q;
  assign bus.data_out  = dout;
`endif

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q | rb_done;
  assign bus.err  = err_q;
endmodule
